cpu_core_mc: RTL
================

Name: cpu_core_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle 8-bit CPU: data width, PC/address width and register count are configurable.
- Fetches from external instruction memory and accesses external data memory over req/ack handshakes, so it tolerates wait states.
- Adds carry flag, JNZ, ADDI, HALT, illegal-opcode detection, retire pulse and a debug register-read port.
- Sits between the instruction ROM and the data RAM at the top level.

Parameters:
- DW, 8, data/register width.
- AW, 8, PC and data-address width; also the immediate width.
- NREG, 4, number of registers (power of two, ≥2). RB = clog2(NREG). Instruction width IW = 4+2*RB+AW (16 at defaults).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  AW  fetch address (= PC)
- imem_rdata  in  IW  instruction, valid when imem_ack
- imem_ack  in  1  fetch complete
- dmem_req  out  1  data request
- dmem_we  out  1  1=store, 0=load
- dmem_addr  out  AW  data address
- dmem_wdata  out  DW  store data
- dmem_rdata  in  DW  load data, valid when dmem_ack
- dmem_ack  in  1  data access complete
- pc_out  out  AW  current PC
- zero_flag  out  1  Z flag
- carry_flag  out  1  C flag
- halted  out  1  core stopped by HALT
- illegal  out  1  sticky: undefined opcode executed
- retire  out  1  one-cycle pulse per completed instruction
- dbg_sel  in  RB  debug register index
- dbg_rdata  out  DW  R[dbg_sel], combinational

Behaviour:
- Encoding: [IW-1:IW-4] op, next RB bits rd, next RB bits rs, low AW bits imm. imm is zero-extended or truncated to DW where used as data.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd = rd op rs.
  - 6 LDI: rd = imm. 7 LOAD: rd = mem[imm]. 8 STORE: mem[imm] = rd.
  - 9 JMP imm. A JZ imm (taken if Z=1). B JNZ imm (taken if Z=0).
  - C ADDI: rd = rd + imm.
  - F HALT.
  - D, E: illegal. Execute as NOP and set `illegal`.
- Flags:
  - Z is updated by ops 1–5 and C (result==0). It is unchanged by all other ops.
  - C is updated by ADD/ADDI (carry out of DW bits) and SUB (borrow: rd<rs unsigned). It is unchanged by all other ops.
  - Arithmetic wraps modulo 2^DW.
- FSM states: BOOT, FETCH, EXEC, MEM, HALT.
  - BOOT: entered only by reset. Next cycle goes to FETCH.
  - FETCH: imem_req=1, imem_addr=PC. On the cycle with imem_ack=1 (may be the first req cycle), latch the instruction and go to EXEC.
  - EXEC: decode; do ALU/LDI writeback and flag update. PC = imm if a jump is taken, else PC+1 (wraps at 2^AW).
    - LOAD/STORE go to MEM.
    - HALT goes to HALT with PC unchanged.
    - All others go to FETCH and pulse `retire`.
  - MEM: dmem_req=1, dmem_addr=imm, dmem_we=(op==8), dmem_wdata=R[rd].
    - All outputs are held stable until dmem_ack.
    - On ack: LOAD writes rd = dmem_rdata, flags unchanged, PC+1, `retire` pulses, go to FETCH.
  - HALT: no requests. `halted`=1 and `retire` pulses on entry. Only reset exits.
- Latency with zero-wait ack: 2 cycles per instruction, 3 for LOAD/STORE. Each wait cycle adds 1.
- req is never deasserted before its ack. ack while req=0 is ignored.
- Reset (async, rst=0):
  - state=BOOT, PC=RESET_PC, all R=0.
  - Z=C=halted=illegal=retire=0.
  - imem_req=dmem_req=dmem_we=0.
  - Reset mid-transaction abandons it immediately, with no writeback.
- Writes to the same rd in consecutive instructions are seen in order: single register write per instruction.

Test Plan:
- Reset/boot: hold rst=0 3 cycles, release -> imem_req=0 in the BOOT cycle, then 1 with imem_addr=0. All R=0, flags 0.
- Arithmetic: LDI R1,0xFF; ADDI R1,1 -> R1=0x00, Z=1, C=1. Then LDI R2,5; SUB R2,R1 -> R2=5, Z=0, C=0. Each instruction retires 2 cycles apart with zero-wait acks.
- Memory with waits: STORE R2,0x40 with dmem_ack delayed 3 cycles -> dmem_req/addr=0x40/we=1/wdata=5 held stable for 4 cycles. Then LOAD R3,0x40 returning 5 -> R3=5, Z unchanged.
- Branches: LDI R0,0; XOR R0,R0 (Z=1); JZ 0x10 -> next imem_addr=0x10. JNZ 0x20 with Z=1 -> imem_addr=0x11. PC=0xFF with NOP -> wraps to 0x00.
- HALT/illegal: opcode 0xD -> illegal=1, PC+1. HALT -> halted=1, no further imem_req, PC frozen.
- Mid-op reset: assert rst during MEM of a LOAD before ack -> dmem_req drops in the same cycle (async). Target register stays 0 and PC=RESET_PC.

Source files
------------

// File: rtl/cpu_core_mc.sv
// Multi-cycle parametrised CPU core with req/ack instruction and data memory ports.
// Single FSM sequences BOOT -> FETCH -> EXEC [-> MEM] with registered bus outputs.
module cpu_core_mc #(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 8,
  parameter int unsigned NREG     = 4,
  parameter int unsigned RESET_PC = 0,
  localparam int unsigned RB      = $clog2(NREG),
  localparam int unsigned IW      = 4 + 2 * RB + AW
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  input  logic          imem_ack,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic [AW-1:0] pc_out,
  output logic          zero_flag,
  output logic          carry_flag,
  output logic          halted,
  output logic          illegal,
  output logic          retire,
  input  logic [RB-1:0] dbg_sel,
  output logic [DW-1:0] dbg_rdata
);

  typedef enum logic [2:0] {StBoot, StFetch, StExec, StMem, StHalt} state_e;

  localparam logic [3:0] OpNop = 4'h0, OpAdd = 4'h1, OpSub = 4'h2, OpAnd = 4'h3;
  localparam logic [3:0] OpOr = 4'h4, OpXor = 4'h5, OpLdi = 4'h6, OpLoad = 4'h7;
  localparam logic [3:0] OpStore = 4'h8, OpJmp = 4'h9, OpJz = 4'hA, OpJnz = 4'hB;
  localparam logic [3:0] OpAddi = 4'hC, OpIllD = 4'hD, OpIllE = 4'hE, OpHalt = 4'hF;

  state_e          r_state;
  logic [AW-1:0]   r_pc;
  logic [IW-1:0]   r_ir;
  logic [DW-1:0]   r_regs [NREG];
  logic            r_z, r_c, r_halted, r_illegal, r_retire;
  logic            r_imem_req, r_dmem_req, r_dmem_we;
  logic [AW-1:0]   r_dmem_addr;
  logic [DW-1:0]   r_dmem_wdata;

  logic [3:0]      w_op;
  logic [RB-1:0]   w_rd, w_rs;
  logic [AW-1:0]   w_imm;
  logic [DW-1:0]   w_imm_dw, w_rd_val, w_rs_val, w_res;
  logic            w_carry, w_wr, w_upd_z, w_upd_c, w_taken;

  assign w_op     = r_ir[IW-1 -: 4];
  assign w_rd     = r_ir[IW-5 -: RB];
  assign w_rs     = r_ir[IW-5-RB -: RB];
  assign w_imm    = r_ir[AW-1:0];
  assign w_imm_dw = DW'(w_imm);
  assign w_rd_val = r_regs[w_rd];
  assign w_rs_val = r_regs[w_rs];

  always_comb begin
    w_res   = w_rd_val;
    w_carry = r_c;
    w_wr    = 1'b0;
    w_upd_z = 1'b0;
    w_upd_c = 1'b0;
    w_taken = 1'b0;
    case (w_op)
      OpAdd: begin
        {w_carry, w_res} = {1'b0, w_rd_val} + {1'b0, w_rs_val};
        w_wr = 1'b1; w_upd_z = 1'b1; w_upd_c = 1'b1;
      end
      OpSub: begin
        w_res   = w_rd_val - w_rs_val;
        w_carry = (w_rd_val < w_rs_val);
        w_wr = 1'b1; w_upd_z = 1'b1; w_upd_c = 1'b1;
      end
      OpAnd: begin w_res = w_rd_val & w_rs_val; w_wr = 1'b1; w_upd_z = 1'b1; end
      OpOr:  begin w_res = w_rd_val | w_rs_val; w_wr = 1'b1; w_upd_z = 1'b1; end
      OpXor: begin w_res = w_rd_val ^ w_rs_val; w_wr = 1'b1; w_upd_z = 1'b1; end
      OpLdi: begin w_res = w_imm_dw; w_wr = 1'b1; end
      OpAddi: begin
        {w_carry, w_res} = {1'b0, w_rd_val} + {1'b0, w_imm_dw};
        w_wr = 1'b1; w_upd_z = 1'b1; w_upd_c = 1'b1;
      end
      OpJmp: w_taken = 1'b1;
      OpJz:  w_taken = r_z;
      OpJnz: w_taken = ~r_z;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StBoot;
      r_pc         <= AW'(RESET_PC);
      r_ir         <= '0;
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
      r_z          <= 1'b0;
      r_c          <= 1'b0;
      r_halted     <= 1'b0;
      r_illegal    <= 1'b0;
      r_retire     <= 1'b0;
      r_imem_req   <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        StBoot: begin
          r_state    <= StFetch;
          r_imem_req <= 1'b1;
        end
        StFetch: begin
          if (imem_ack) begin
            r_ir       <= imem_rdata;
            r_imem_req <= 1'b0;
            r_state    <= StExec;
          end
        end
        StExec: begin
          if (w_wr) r_regs[w_rd] <= w_res;
          if (w_upd_z) r_z <= (w_res == '0);
          if (w_upd_c) r_c <= w_carry;
          if (w_op == OpIllD || w_op == OpIllE) r_illegal <= 1'b1;
          if (w_op == OpLoad || w_op == OpStore) begin
            // Bus fields are latched here so they stay stable through wait states.
            r_state      <= StMem;
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= (w_op == OpStore);
            r_dmem_addr  <= w_imm;
            r_dmem_wdata <= w_rd_val;
          end else if (w_op == OpHalt) begin
            r_state  <= StHalt;
            r_halted <= 1'b1;
            r_retire <= 1'b1;
          end else begin
            r_pc       <= w_taken ? w_imm : r_pc + AW'(1);
            r_state    <= StFetch;
            r_imem_req <= 1'b1;
            r_retire   <= 1'b1;
          end
        end
        StMem: begin
          if (dmem_ack) begin
            if (!r_dmem_we) r_regs[w_rd] <= dmem_rdata;
            r_pc       <= r_pc + AW'(1);
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_retire   <= 1'b1;
            r_state    <= StFetch;
            r_imem_req <= 1'b1;
          end
        end
        StHalt: ;
        default: r_state <= StBoot;
      endcase
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_pc;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign pc_out     = r_pc;
  assign zero_flag  = r_z;
  assign carry_flag = r_c;
  assign halted     = r_halted;
  assign illegal    = r_illegal;
  assign retire     = r_retire;
  assign dbg_rdata  = r_regs[dbg_sel];

endmodule
